// File: rtl/key_expansion.sv
// -----------------------------------------------------------------------------
// key_expansion
//   AES-128 key schedule. The 128-bit cipher key arrives bit-serially (MSB
//   first) and is shifted into Key_0. The block then derives Key_1..Key_10,
//   one round per clock. KEY_VAL rises once all eleven round keys are stable.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   KIN            serial key bit, key bit 127 first
//   EN             load/run enable; low on an edge aborts back to IDLE
//   Key_0..Key_10  registered round keys (Key_0 = cipher key)
//   KEY_VAL        registered; high while Key_0..Key_10 are valid
// -----------------------------------------------------------------------------
module key_expansion (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         KIN,
    input  logic         EN,
    output logic [127:0] Key_0,
    output logic [127:0] Key_1,
    output logic [127:0] Key_2,
    output logic [127:0] Key_3,
    output logic [127:0] Key_4,
    output logic [127:0] Key_5,
    output logic [127:0] Key_6,
    output logic [127:0] Key_7,
    output logic [127:0] Key_8,
    output logic [127:0] Key_9,
    output logic [127:0] Key_10,
    output logic         KEY_VAL
);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at byte position 255-x counted from the LSB; 255-x == ~x.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [6:0]     bit_cnt_reg;
    logic [3:0]     rnd_reg;
    logic           key_val_reg;
    logic [127:0]   keys_reg [0:10];

    logic [127:0]   prev_key;
    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [7:0]     rcon;
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   next_key;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (!EN) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = LOAD;
                LOAD:    if (bit_cnt_reg == 7'd127) state_next = EXPAND;
                EXPAND:  if (rnd_reg == 4'd10) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // ------------------------------------------------------------------
    // Counters and valid flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_reg <= 7'd0;
            rnd_reg     <= 4'd1;
            key_val_reg <= 1'b0;
        end else if (!EN) begin
            bit_cnt_reg <= 7'd0;
            rnd_reg     <= 4'd1;
            key_val_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= 7'd1;
                end
                LOAD: begin
                    // bit_cnt reaches 127 exactly on the last bit, then exits;
                    // it therefore never wraps.
                    if (bit_cnt_reg == 7'd127) begin
                        rnd_reg <= 4'd1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 7'd1;
                    end
                end
                EXPAND: begin
                    rnd_reg <= rnd_reg + 4'd1;
                    if (rnd_reg == 4'd10) key_val_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round function, shared by all rounds
    // ------------------------------------------------------------------
    assign prev_key = keys_reg[rnd_reg - 4'd1];
    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
        end
    endgenerate

    always_comb begin
        rcon = 8'h00;
        case (rnd_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign n0       = prev_key[127:96] ^ sub_word ^ {rcon, 24'h0};
    assign n1       = prev_key[95:64]  ^ n0;
    assign n2       = prev_key[63:32]  ^ n1;
    assign n3       = prev_key[31:0]   ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // ------------------------------------------------------------------
    // Key registers
    // ------------------------------------------------------------------
    // Key_0 is the serial shift register; a new load always reshifts all
    // 128 bits, so any partial key from an abort is overwritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys_reg[0] <= 128'h0;
        end else if (EN && (state_reg == IDLE || state_reg == LOAD)) begin
            keys_reg[0] <= {keys_reg[0][126:0], KIN};
        end
    end

    // Only the round key addressed by rnd is written on an EXPAND edge.
    generate
        for (genvar gi = 1; gi <= 10; gi++) begin : g_round_key
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    keys_reg[gi] <= 128'h0;
                end else if (EN && state_reg == EXPAND && rnd_reg == 4'(gi)) begin
                    keys_reg[gi] <= next_key;
                end
            end
        end
    endgenerate

    assign Key_0   = keys_reg[0];
    assign Key_1   = keys_reg[1];
    assign Key_2   = keys_reg[2];
    assign Key_3   = keys_reg[3];
    assign Key_4   = keys_reg[4];
    assign Key_5   = keys_reg[5];
    assign Key_6   = keys_reg[6];
    assign Key_7   = keys_reg[7];
    assign Key_8   = keys_reg[8];
    assign Key_9   = keys_reg[9];
    assign Key_10  = keys_reg[10];
    assign KEY_VAL = key_val_reg;

endmodule

// File: tb/tb_key_expansion.sv
// -----------------------------------------------------------------------------
// tb_key_expansion
//   Self-checking bench for key_expansion: known-answer table, abort/reset/
//   reload sequences, and random keys against a reference key schedule built
//   from GF(2^8) arithmetic.
// -----------------------------------------------------------------------------
module tb_key_expansion;

    logic         clk;
    logic         reset_n;
    logic         KIN;
    logic         EN;
    logic [127:0] Key_0, Key_1, Key_2, Key_3, Key_4, Key_5;
    logic [127:0] Key_6, Key_7, Key_8, Key_9, Key_10;
    logic         KEY_VAL;

    key_expansion dut (
        .clk     (clk),
        .reset_n (reset_n),
        .KIN     (KIN),
        .EN      (EN),
        .Key_0   (Key_0),
        .Key_1   (Key_1),
        .Key_2   (Key_2),
        .Key_3   (Key_3),
        .Key_4   (Key_4),
        .Key_5   (Key_5),
        .Key_6   (Key_6),
        .Key_7   (Key_7),
        .Key_8   (Key_8),
        .Key_9   (Key_9),
        .Key_10  (Key_10),
        .KEY_VAL (KEY_VAL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_ref [256];
    logic [127:0] exp_keys [11];

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x;
            x = xtime(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        return t[15-n -: 8];
    endfunction

    // S-box = affine transform of the multiplicative inverse (b^254).
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] b   = 8'(v);
            logic [7:0] inv = 8'h01;
            if (v == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gf_mul(inv, b);
            sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t ^= {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    function automatic logic [127:0] dut_key(input int i);
        case (i)
            0: return Key_0;   1: return Key_1;   2: return Key_2;
            3: return Key_3;   4: return Key_4;   5: return Key_5;
            6: return Key_6;   7: return Key_7;   8: return Key_8;
            9: return Key_9;   default: return Key_10;
        endcase
    endfunction

    task automatic chk128(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Forces IDLE with one EN-low edge, then shifts nbits of key MSB first.
    task automatic shift_bits(input logic [127:0] key, input int nbits);
        EN = 1'b0;
        step();
        chk1("kv_idle", KEY_VAL, 1'b0);
        EN = 1'b1;
        for (int i = 127; i > 127 - nbits; i--) begin
            KIN = key[i];
            step();
            chk1("kv_load", KEY_VAL, 1'b0);
        end
    endtask

    // Full load: 128 shift edges plus 10 expansion edges; KEY_VAL must rise
    // exactly after the 138th EN-high edge.
    task automatic load_key(input logic [127:0] key);
        shift_bits(key, 128);
        repeat (9) begin
            step();
            chk1("kv_expand", KEY_VAL, 1'b0);
        end
        step();
        chk1("kv_rise", KEY_VAL, 1'b1);
    endtask

    task automatic check_all(input string tag, input logic [127:0] key);
        model_expand(key);
        for (int r = 0; r < 11; r++)
            chk128($sformatf("%s_key%0d", tag, r), dut_key(r), exp_keys[r]);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] k1;
        logic [127:0] k10;
    } vec_t;

    vec_t vecs [2];

    initial begin
        logic [127:0] key1;
        logic [127:0] rkey;
        logic [127:0] held;

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{128'h0,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        key1 = vecs[0].key;

        build_sbox();

        reset_n = 1'b0;
        EN      = 1'b0;
        KIN     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int r = 0; r < 11; r++) chk128($sformatf("reset_key%0d", r), dut_key(r), 128'h0);
        chk1("reset_kv", KEY_VAL, 1'b0);
        reset_n = 1'b1;

        // Known-answer table
        for (int v = 0; v < 2; v++) begin
            load_key(vecs[v].key);
            chk128($sformatf("kat%0d_key0", v), Key_0, vecs[v].key);
            chk128($sformatf("kat%0d_key1", v), Key_1, vecs[v].k1);
            chk128($sformatf("kat%0d_key10", v), Key_10, vecs[v].k10);
            check_all($sformatf("kat%0d", v), vecs[v].key);
            $display("kat %0d key %h key10 %h kv %b", v, vecs[v].key, Key_10, KEY_VAL);
        end

        // Abort after 60 bits, then full reload
        shift_bits(128'hffff_0000_ffff_0000_ffff_0000_ffff_0000, 60);
        EN = 1'b0;
        repeat (4) begin
            step();
            chk1("abort_kv", KEY_VAL, 1'b0);
        end
        load_key(key1);
        chk128("abort_reload_key1", Key_1, vecs[0].k1);
        chk128("abort_reload_key10", Key_10, vecs[0].k10);
        $display("abort-reload key10 %h", Key_10);

        // Async reset during EXPAND at rnd=5
        shift_bits(vecs[1].key, 128);
        repeat (4) step();
        #2 reset_n = 1'b0;
        #1;
        for (int r = 0; r < 11; r++) chk128($sformatf("midreset_key%0d", r), dut_key(r), 128'h0);
        chk1("midreset_kv", KEY_VAL, 1'b0);
        reset_n = 1'b1;
        #1;
        load_key(key1);
        check_all("post_reset", key1);
        $display("post-reset key10 %h", Key_10);

        // DONE hold for 50 cycles, then single EN-low edge and new key
        held = Key_10;
        repeat (50) begin
            step();
            chk1("hold_kv", KEY_VAL, 1'b1);
            chk128("hold_key10", Key_10, held);
        end
        load_key(128'h0);
        chk128("reload_key1", Key_1, vecs[1].k1);
        chk128("reload_key10", Key_10, vecs[1].k10);
        $display("hold-reload key10 %h", Key_10);

        // Random keys vs reference model
        for (int n = 0; n < 400; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            load_key(rkey);
            check_all("rand", rkey);
            $display("rand %0d key %h key10 %h", n, rkey, Key_10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
